// File: rtl/timer_arbiter_pkg.sv
// Shared types for the timer arbiter.
// FSM state encoding and default sizing.
package timer_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ      = 4;
  localparam int DEFAULT_NUM_CNT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter with programmable rollover and registered flag.
// Ports: clk, n_rst, clear, count_enable, rollover_val -> count_out, rollover_flag.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] cnt_d;
  logic                    flag_d;

  always_comb begin
    cnt_d = count_out;
    if (clear) begin
      cnt_d = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        cnt_d = NUM_CNT_BITS'(1);
      end else begin
        cnt_d = count_out + NUM_CNT_BITS'(1);
      end
    end
    // Flag tracks the value the counter is about to hold.
    flag_d = !clear && (cnt_d == rollover_val);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= cnt_d;
      rollover_flag <= flag_d;
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin sharing of one flex_counter among NUM_REQ requesters.
// Ports: clk, n_rst, req, delay_val -> grant (one-hot), done (pulse), busy.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int NUM_CNT_BITS = DEFAULT_NUM_CNT_BITS
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] delay_val,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [PW-1:0]           idx_t;
  typedef logic [NUM_CNT_BITS-1:0] cnt_t;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  idx_t               ptr_q, ptr_d;
  idx_t               gidx_q, gidx_d;
  cnt_t               delay_q, delay_d;

  logic cnt_clear;
  logic cnt_en;
  logic cnt_flag;
  cnt_t count_out;
  cnt_t dly [NUM_REQ];
  idx_t win;

  // First set bit at or above p, wrapping past the top index.
  function automatic idx_t rr_pick(
    input logic [NUM_REQ-1:0] r,
    input idx_t               p
  );
    idx_t w;
    logic hit;
    int   j;
    w   = p;
    hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(p) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!hit && r[idx_t'(j)]) begin
        hit = 1'b1;
        w   = idx_t'(j);
      end
    end
    return w;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      dly[i] = delay_val[i*NUM_CNT_BITS +: NUM_CNT_BITS];
    end
  end

  assign win = rr_pick(req, ptr_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    delay_d   = delay_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = LOAD;
          gidx_d  = win;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          // A zero delay would never raise the flag; treat it as one.
          delay_d = (dly[win] == '0) ? cnt_t'(1) : dly[win];
        end
      end
      LOAD: begin
        cnt_clear = 1'b1;
        state_d   = COUNT;
      end
      COUNT: begin
        // Freeze at the rollover value instead of wrapping.
        cnt_en = !cnt_flag;
        if (cnt_flag) begin
          state_d = DONE;
          done_d  = grant_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        if (gidx_q == idx_t'(NUM_REQ-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = gidx_q + idx_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      delay_q <= delay_d;
    end
  end

  flex_counter #(
    .NUM_CNT_BITS(NUM_CNT_BITS)
  ) u_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (delay_q),
    .count_out    (count_out),
    .rollover_flag(cnt_flag)
  );

  // Count value is kept for debug visibility only.
  logic unused_cnt;
  assign unused_cnt = ^count_out;

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);

endmodule
